ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
Parametrised multi-cycle multiply/divide execute unit for the RV32M extension. It sits beside the single-cycle execute ALU in the EX stage.
- Accepts one operation when idle and iterates over several cycles.
- Holds the pipeline via a stall request while busy.
- Presents a one-cycle result with the destination register for the EX/MEM latch.
- Supports flush (branch mispredict) abort.

Parameters:
XLEN, 32, operand/result width (>=8, power of 2)
MUL_UNROLL, 4, multiplier bits consumed per CALC cycle; must divide XLEN
REG_ADDR_W, 5, destination register address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start_i  in  1  valid M-extension op presented this cycle
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1_i  in  XLEN  rs1 value
op2_i  in  XLEN  rs2 value
wd_i  in  REG_ADDR_W  destination register
flush_i  in  1  abort current operation
busy_o  out  1  unit not idle
stall_req_o  out  1  hold IF/ID/EX
done_o  out  1  result valid (one-cycle pulse)
result_o  out  XLEN  result
wd_o  out  REG_ADDR_W  destination of result
wreg_o  out  1  write-back enable (equals done_o)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0; internal accumulators 0.
- FSM states: IDLE, CALC, DONE.
- IDLE + start_i=1 + flush_i=0:
  - Latch op, wd_i, operand magnitudes and sign flags.
  - MUL/MULH: both operands signed. MULHSU: op1 signed, op2 unsigned. MULHU: both unsigned.
  - DIV/REM signed; DIVU/REMU unsigned.
  - Special cases go directly to DONE.
  - Otherwise go to CALC with counter = 0.
- Special cases, resolved without iteration:
  - Divide by zero: DIV/DIVU result all-ones; REM/REMU result = op1_i.
  - Signed overflow (op1 = 1<<(XLEN-1), op2 = all-ones): DIV result = op1; REM result = 0.
- CALC, multiply:
  - Shift-add over a 2*XLEN accumulator, MUL_UNROLL bits per cycle.
  - XLEN/MUL_UNROLL cycles.
- CALC, divide:
  - Restoring radix-2, one quotient bit per cycle.
  - XLEN cycles.
- On last CALC iteration:
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
  - Select field: MUL low XLEN; MULH* high XLEN; DIV* quotient; REM* remainder.
  - Register into result_o and go to DONE.
- DONE: done_o=wreg_o=1 and wd_o valid for exactly one cycle; return to IDLE.
- Outputs in IDLE/CALC:
  - result_o holds its last value.
  - done_o=wreg_o=0.
- Latency: start accepted in cycle 0; done_o in cycle N+1.
  - Mul: N = XLEN/MUL_UNROLL (8 at defaults).
  - Div: N = XLEN (32).
  - Special cases: N = 0.
- stall_req_o:
  - = (IDLE & start_i & ~flush_i) | CALC. Combinational, so the issuing cycle is stalled.
  - Low in DONE, so the pipeline advances as the result is written.
- busy_o = state != IDLE.
- start_i while not IDLE: ignored; no queuing.
- flush_i=1 in any state: next state IDLE, no done_o pulse.
  - Pending result discarded; result_o retains its old value.
  - flush_i has priority over start_i in the same cycle.
- flush_i in DONE: the done_o pulse of that cycle still asserts (the result was architecturally committed before the flush).
- Reset mid-operation: immediate IDLE, outputs 0.
- Arithmetic: all intermediate widths fixed by XLEN; no truncation before final field select.

Decomposition:
- Shared package/define file: funct3 op codes (MDU_MUL..MDU_REMU), state encodings, XLEN-derived widths, ZeroWord-style constants sized by XLEN.
- One natural sub-module: mdu_sign_fix. Combinational abs/negate and sign-correction helper, instantiated for operands and result.

Test Plan:
- MUL 7 * -3, XLEN=32 -> done_o 9 cycles after start; result 0xFFFFFFEB; stall_req_o high cycles 0..8.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> -3 (0xFFFFFFFD) after 33 cycles. REM -7 % 2 -> -1. DIVU 100 / 7 -> 14. REMU -> 2.
- DIVU x / 0 -> 0xFFFFFFFF; REM 5 % 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000; REM -> 0. Each with done_o at cycle 1.
- Flush: DIV started, flush_i asserted in cycle 10 -> no done_o, busy_o low at cycle 11; new MUL starting at cycle 11 completes correctly with its own wd_o.
- Reset: assert rst low during CALC -> all outputs 0 immediately. start_i asserted while busy -> ignored; only the first op's done_o appears.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit:
// funct3 operation codes, FSM states and operand signedness helpers.
package ex_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    localparam int unsigned MDU_XLEN_DEFAULT = 32;

    function automatic logic op1_signed(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op2_signed(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/ex_mdu_sign_fix.sv
// Conditional two's-complement negate: absolute value of operands and
// sign correction of the unsigned iteration result.
module mdu_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    always_comb begin
        val_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply (MUL_UNROLL
// bits per cycle), restoring radix-2 divide, stall request while busy.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int unsigned XLEN       = MDU_XLEN_DEFAULT,
    parameter int unsigned MUL_UNROLL = 4,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       op1_i,
    input  logic [XLEN-1:0]       op2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);

    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(XLEN / MUL_UNROLL - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ZERO_WORD = '0;
    localparam logic [XLEN-1:0]  ONES_WORD = '1;
    localparam logic [XLEN-1:0]  MIN_WORD  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e            state_q, state_d;
    mdu_op_e               op_q, op_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic [DW-1:0]         mcand_q, mcand_d;
    logic [XLEN-1:0]       mplier_q, mplier_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]       result_q, result_d;

    mdu_op_e         op_in;
    logic            neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] abs1, abs2;

    assign op_in = mdu_op_e'(op_i);
    assign neg1  = op1_signed(op_in) & op1_i[XLEN-1];
    assign neg2  = op2_signed(op_in) & op2_i[XLEN-1];

    mdu_sign_fix #(.W(XLEN)) u_abs1 (.val_i(op1_i), .neg_i(neg1), .val_o(abs1));
    mdu_sign_fix #(.W(XLEN)) u_abs2 (.val_i(op2_i), .neg_i(neg2), .val_o(abs2));

    assign div_zero = (op2_i == ZERO_WORD);
    assign div_ovf  = (op_in inside {MDU_DIV, MDU_REM}) &&
                      (op1_i == MIN_WORD) && (op2_i == ONES_WORD);

    logic [DW-1:0]   mul_nxt, div_nxt, prod_fix;
    logic [XLEN:0]   rem_shift, div_diff;
    logic [XLEN-1:0] quot_fix, rem_fix, calc_result;

    always_comb begin
        mul_nxt = acc_q;
        for (int unsigned i = 0; i < MUL_UNROLL; i++) begin
            if (mplier_q[i]) mul_nxt = mul_nxt + (mcand_q << i);
        end
    end

    // Divide packs {remainder, dividend/quotient} into acc_q; divisor sits in mcand_q low half.
    always_comb begin
        rem_shift = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
        div_diff  = rem_shift - {1'b0, mcand_q[XLEN-1:0]};
        if (div_diff[XLEN]) div_nxt = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else                div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    mdu_sign_fix #(.W(DW))   u_fix_prod (.val_i(mul_nxt), .neg_i(neg_q), .val_o(prod_fix));
    mdu_sign_fix #(.W(XLEN)) u_fix_quot (.val_i(div_nxt[XLEN-1:0]), .neg_i(neg_q), .val_o(quot_fix));
    mdu_sign_fix #(.W(XLEN)) u_fix_rem  (.val_i(div_nxt[DW-1:XLEN]), .neg_i(rem_neg_q), .val_o(rem_fix));

    always_comb begin
        case (op_q)
            MDU_MUL:                        calc_result = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_result = prod_fix[DW-1:XLEN];
            MDU_DIV, MDU_DIVU:              calc_result = quot_fix;
            default:                        calc_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wd_d      = wd_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d      = op_in;
                    wd_d      = wd_i;
                    neg_d     = neg1 ^ neg2;
                    rem_neg_d = neg1;
                    cnt_d     = '0;
                    if (op_i[2] && div_zero) begin
                        result_d = op_i[1] ? op1_i : ONES_WORD;
                        state_d  = ST_DONE;
                    end else if (div_ovf) begin
                        result_d = op_i[1] ? ZERO_WORD : op1_i;
                        state_d  = ST_DONE;
                    end else if (op_i[2]) begin
                        acc_d   = {ZERO_WORD, abs1};
                        mcand_d = {ZERO_WORD, abs2};
                        state_d = ST_CALC;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = {ZERO_WORD, abs1};
                        mplier_d = abs2;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    acc_d = div_nxt;
                end else begin
                    acc_d    = mul_nxt;
                    mcand_d  = mcand_q << MUL_UNROLL;
                    mplier_d = mplier_q >> MUL_UNROLL;
                end
                if (cnt_q == (op_q[2] ? DIV_LAST : MUL_LAST)) begin
                    result_d = calc_result;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MDU_MUL;
            wd_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wd_q      <= wd_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign stall_req_o = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_CALC);
    assign done_o      = (state_q == ST_DONE);
    assign wreg_o      = done_o;
    assign result_o    = result_q;
    assign wd_o        = wd_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed RV32M cases, randomized ops
// against an arithmetic reference model, flush, reset and busy behaviour.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  wd_i;
    logic        busy_o, stall_req_o, done_o, wreg_o;
    logic [31:0] result_o;
    logic [4:0]  wd_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res = '0;

    ex_mdu #(.XLEN(32), .MUL_UNROLL(4), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .op1_i(op1_i), .op2_i(op2_i), .wd_i(wd_i), .flush_i(flush_i),
        .busy_o(busy_o), .stall_req_o(stall_req_o), .done_o(done_o),
        .result_o(result_o), .wd_o(wd_o), .wreg_o(wreg_o)
    );

    always #5 clk = ~clk;

    // RV32M semantics in 64-bit arithmetic; the signed overflow case falls out naturally.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 9;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Caller is at a negedge; collects observations of one operation, no checking.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] w,
                         output int lat, output logic [31:0] res, output logic [4:0] wdo,
                         output bit stall_ok, output bit wreg_ok);
        start_i = 1'b1; op_i = o; op1_i = a; op2_i = b; wd_i = w;
        #1 stall_ok = stall_req_o;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        lat = 0; res = '0; wdo = '0; wreg_ok = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (done_o) begin
                lat = k; res = result_o; wdo = wd_o; wreg_ok = wreg_o;
                if (stall_req_o) stall_ok = 1'b0;
                break;
            end
            if (!stall_req_o) stall_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; op1_i = '0; op2_i = '0; wd_i = '0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy_o, stall_req_o, done_o, wreg_o} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags got %b need 0000", {busy_o, stall_req_o, done_o, wreg_o});
        end
        n_cmp++;
        if (result_o !== 32'h0) begin n_err++; $display("FAIL reset_result got %h need 0", result_o); end
        n_cmp++;
        if (wd_o !== 5'h0) begin n_err++; $display("FAIL reset_wd got %h need 0", wd_o); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [2:0]  t_op [12];
        logic [31:0] t_a  [12];
        logic [31:0] t_b  [12];
        logic [31:0] t_r  [12];
        int          t_l  [12];
        int lat; logic [31:0] res; logic [4:0] wdo; bit sok, wok;
        t_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        t_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                 32'd100, 32'd100, 32'h0000_1234, 32'd5, 32'h8000_0000, 32'h8000_0000};
        t_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_r  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        t_l  = '{9, 9, 9, 9, 33, 33, 33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            issue(t_op[i], t_a[i], t_b[i], 5'(i + 1), lat, res, wdo, sok, wok);
            n_cmp++;
            if (res !== t_r[i]) begin n_err++; $display("FAIL dir%0d_result got %h need %h", i, res, t_r[i]); end
            n_cmp++;
            if (lat !== t_l[i]) begin n_err++; $display("FAIL dir%0d_latency got %0d need %0d", i, lat, t_l[i]); end
            n_cmp++;
            if (wdo !== 5'(i + 1)) begin n_err++; $display("FAIL dir%0d_wd got %0d need %0d", i, wdo, i + 1); end
            n_cmp++;
            if ({sok, wok} !== 2'b11) begin n_err++; $display("FAIL dir%0d_stall_wreg got %b need 11", i, {sok, wok}); end
            last_res = t_r[i];
        end
    endtask

    task automatic test_random;
        logic [2:0] o; logic [31:0] a, b, er; logic [4:0] w;
        int lat, el; logic [31:0] res; logic [4:0] wdo; bit sok, wok;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; w = 5'($urandom);
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = -32'($urandom_range(1, 1000));
                default: ;
            endcase
            er = ref_result(o, a, b);
            el = ref_latency(o, a, b);
            @(negedge clk);
            issue(o, a, b, w, lat, res, wdo, sok, wok);
            n_cmp++;
            if (res !== er || lat !== el || wdo !== w || !sok || !wok) begin
                n_err++;
                $display("FAIL rnd%0d op%0d a=%h b=%h got res=%h lat=%0d wd=%0d stall=%b wreg=%b need res=%h lat=%0d wd=%0d stall=1 wreg=1",
                         i, o, a, b, res, lat, wdo, sok, wok, er, el, w);
            end
            last_res = er;
        end
    endtask

    task automatic test_flush;
        int seen; int lat; logic [31:0] res; logic [4:0] wdo; bit sok, wok;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; op1_i = 32'hFFFF_FFF9; op2_i = 32'd2; wd_i = 5'd4;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b need 0", busy_o); end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL flush_no_done got %0d pulses need 0", seen); end
        n_cmp++;
        if (result_o !== last_res) begin n_err++; $display("FAIL flush_result_hold got %h need %h", result_o, last_res); end
        issue(3'd0, 32'd123, -32'd45, 5'd17, lat, res, wdo, sok, wok);
        n_cmp++;
        if (res !== -32'd5535 || lat !== 9 || wdo !== 5'd17) begin
            n_err++; $display("FAIL flush_next_mul got res=%h lat=%0d wd=%0d need res=%h lat=9 wd=17", res, lat, wdo, -32'd5535);
        end
        last_res = -32'd5535;

        // Flush coinciding with DONE: the pulse is still presented.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; op1_i = 32'd9; op2_i = 32'd0; wd_i = 5'd6;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b1;
        #1;
        n_cmp++;
        if ({done_o, wreg_o} !== 2'b11 || result_o !== 32'hFFFF_FFFF || wd_o !== 5'd6) begin
            n_err++; $display("FAIL flush_in_done got done=%b wreg=%b res=%h wd=%0d need 1 1 ffffffff 6", done_o, wreg_o, result_o, wd_o);
        end
        last_res = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;

        // Start and flush together in IDLE: flush wins.
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; op1_i = 32'd3; op2_i = 32'd3; wd_i = 5'd8;
        #1;
        n_cmp++;
        if (stall_req_o !== 1'b0) begin n_err++; $display("FAIL flush_start_stall got %b need 0", stall_req_o); end
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0; seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy_o || done_o) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL flush_start_ignored got %0d active cycles need 0", seen); end
    endtask

    task automatic test_start_while_busy;
        int pulses, lat; logic [31:0] res; logic [4:0] wdo;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; op1_i = 32'd25; op2_i = -32'd4; wd_i = 5'd3;
        @(posedge clk);
        @(negedge clk);
        pulses = 0; lat = 0; res = '0; wdo = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c <= 4) begin start_i = 1'b1; op_i = 3'd5; op1_i = 32'd77; op2_i = 32'd5; wd_i = 5'd9; end
            else start_i = 1'b0;
            if (done_o) begin
                pulses++;
                if (pulses == 1) begin lat = c; res = result_o; wdo = wd_o; end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pulses !== 1) begin n_err++; $display("FAIL busy_pulses got %0d need 1", pulses); end
        n_cmp++;
        if (res !== 32'hFFFF_FF9C || lat !== 9 || wdo !== 5'd3) begin
            n_err++; $display("FAIL busy_first_op got res=%h lat=%0d wd=%0d need ffffff9c 9 3", res, lat, wdo);
        end
        last_res = 32'hFFFF_FF9C;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd3; wd_i = 5'd12;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, stall_req_o, done_o, wreg_o} !== 4'b0 || result_o !== 32'h0 || wd_o !== 5'h0) begin
            n_err++; $display("FAIL reset_mid got flags=%b res=%h wd=%0d need 0000 0 0",
                              {busy_o, stall_req_o, done_o, wreg_o}, result_o, wd_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_mid_idle got busy=%b need 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_while_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
